// File: rtl/addsub_seq_if.sv
// Handshake and data bundle for the sequential add/subtract unit.
// The master drives the request side (start, mode, operands); the
// slave drives status, result and flags.
interface addsub_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             M;
    logic             ACC;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] F;
    logic             sign;
    logic             zero;
    logic             overflow;
    logic             carryOut;

    modport master (
        output start, M, ACC, X, Y,
        input  busy, done, F, sign, zero, overflow, carryOut
    );

    modport slave (
        input  start, M, ACC, X, Y,
        output busy, done, F, sign, zero, overflow, carryOut
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit. Operands are processed CHUNK bits per
// clock, least-significant chunk first, through a CHUNK-bit adder. The
// result register F and the status flags change only on the completing
// edge, so anything displaying them stays stable while an operation runs.
// Subtraction is X + ~Y + 1: B is inverted and the carry seeded with M.
// Accumulate mode takes the current F as operand A for chaining.
// WIDTH must be >= 2 and an integer multiple of CHUNK.
module addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    addsub_seq_if.slave bus
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_op;      // latched operand A (X or F)
    logic [WIDTH-1:0] b_op;      // latched operand B, already inverted for subtract
    logic [WIDTH-1:0] shadow;    // partial sum, filled one chunk per cycle
    logic             c;         // carry between chunks
    logic             m_op;      // latched mode, used for the carry/borrow flag
    logic [KW-1:0]    k;         // index of the chunk being added this cycle

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] result;
    logic             last;

    // Chunk adder and the full-width result as it will look once chunk k is in.
    // NOTE: every output of an always_comb gets a value on every path (here
    // unconditionally at the top); a path that leaves one unassigned infers a latch.
    always_comb begin
        chunk_sum = {1'b0, a_op[int'(k)*CHUNK +: CHUNK]}
                  + {1'b0, b_op[int'(k)*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c};
        result    = shadow;
        result[int'(k)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        last      = (k == KW'(N - 1));
    end

    // Control FSM, chunked datapath and the committed result/flag registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking ones here would create ordering races.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            a_op         <= '0;
            b_op         <= '0;
            shadow       <= '0;
            c            <= 1'b0;
            m_op         <= 1'b0;
            k            <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.F        <= '0;
            bus.sign     <= 1'b0;
            bus.zero     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.carryOut <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is low throughout IDLE, so start is honoured here only.
                    if (bus.start) begin
                        a_op     <= bus.ACC ? bus.F : bus.X;
                        b_op     <= bus.Y ^ {WIDTH{bus.M}};
                        c        <= bus.M;
                        m_op     <= bus.M;
                        k        <= '0;
                        shadow   <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    shadow <= result;
                    c      <= chunk_sum[CHUNK];
                    k      <= k + 1'b1;
                    if (last) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.F        <= result;
                        bus.sign     <= result[WIDTH-1];
                        bus.zero     <= (result == '0);
                        bus.overflow <= (~a_op[WIDTH-1] & ~b_op[WIDTH-1] &  result[WIDTH-1])
                                      | ( a_op[WIDTH-1] &  b_op[WIDTH-1] & ~result[WIDTH-1]);
                        // Subtract reports borrow, which is the inverted carry.
                        bus.carryOut <= m_op ^ chunk_sum[CHUNK];
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq. Drivers push the expected response of
// each accepted operation into a queue; monitors pop and compare whenever
// done is seen. The main instance is WIDTH=8/CHUNK=4 with directed and
// random operations; three further instances cover 8/8, 16/4 and 12/2.
module tb_addsub_seq;

    localparam int W = 8;
    localparam int C = 4;
    localparam int N = W / C;

    typedef struct {
        logic [31:0] f;
        logic [3:0]  flags;      // {sign, zero, overflow, carryOut}
        int          start_cyc;
    } exp_t;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    logic rst_sw = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^w, signed range test for overflow.
    function automatic exp_t model(input int w, input logic m, input logic [31:0] a, input logic [31:0] y);
        exp_t   e;
        longint md, ua, uy, r, sa, sy, sr;
        md = longint'(1) << w;
        ua = longint'(a);
        uy = longint'(y);
        r  = m ? ua - uy : ua + uy;
        e.flags[0] = m ? (ua < uy) : (r >= md);
        r  = (r + md) % md;
        sa = (ua >= md / 2) ? ua - md : ua;
        sy = (uy >= md / 2) ? uy - md : uy;
        sr = m ? sa - sy : sa + sy;
        e.flags[1] = (sr < -(md / 2)) || (sr >= md / 2);
        e.flags[2] = (r == 0);
        e.flags[3] = (r >= md / 2);
        e.f = 32'(r);
        e.start_cyc = 0;
        return e;
    endfunction

    // ---------------- main instance (8/4) ----------------
    addsub_seq_if #(.WIDTH(W)) bus ();
    addsub_seq #(.WIDTH(W), .CHUNK(C)) u_dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));

    exp_t        q0[$];
    exp_t        me;
    logic [31:0] model_f0 = 0;   // F the model expects after the last issued op
    logic [31:0] shown_f0 = 0;   // F that must be visible until the next done
    int          dones0 = 0;

    always @(negedge CLOCK) begin
        if (!RESET) begin
            if (bus.done) begin
                dones0++;
                check("done_busy_excl", 32'(bus.busy), 0);
                if (q0.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 0);
                end else begin
                    me = q0.pop_front();
                    check("F", 32'(bus.F), me.f);
                    check("flags", {28'b0, bus.sign, bus.zero, bus.overflow, bus.carryOut}, 32'(me.flags));
                    check("latency", 32'(cyc - me.start_cyc), N);
                    shown_f0 = me.f;
                end
            end else if (bus.busy) begin
                check("F_hold", 32'(bus.F), shown_f0);
            end
        end
    end

    task automatic issue(input logic m, input logic acc, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   t;
        t = 0;
        @(negedge CLOCK);
        while (bus.busy) begin
            t++;
            if (t > 50) begin
                check("issue_wait", 32'(bus.busy), 0);
                return;
            end
            @(negedge CLOCK);
        end
        bus.start = 1'b1;
        bus.M     = m;
        bus.ACC   = acc;
        bus.X     = x;
        bus.Y     = y;
        e = model(W, m, acc ? model_f0 : 32'(x), 32'(y));
        e.start_cyc = cyc + 1;
        model_f0 = e.f;
        q0.push_back(e);
        @(posedge CLOCK);
        #1;
        bus.start = 1'b0;
        bus.M     = 1'($urandom);
        bus.ACC   = 1'($urandom);
        bus.X     = W'($urandom);
        bus.Y     = W'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q0.size() != 0 || bus.busy) begin
            @(negedge CLOCK);
            t++;
            if (t > 50) begin
                check("drain_timeout", 32'(q0.size()), 0);
                q0.delete();
                return;
            end
        end
    endtask

    task automatic check_res(input string name, input logic [7:0] f, input logic [3:0] flags);
        check({name, "_F"}, 32'(bus.F), 32'(f));
        check({name, "_flags"}, {28'b0, bus.sign, bus.zero, bus.overflow, bus.carryOut}, 32'(flags));
    endtask

    // ---------------- parameter sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 8 : (g == 1) ? 16 : 12;
        localparam int SC = (g == 0) ? 8 : (g == 1) ? 4 : 2;
        localparam int SN = SW / SC;

        addsub_seq_if #(.WIDTH(SW)) sbus ();
        addsub_seq #(.WIDTH(SW), .CHUNK(SC)) u_dut (.CLOCK(CLOCK), .RESET(rst_sw), .bus(sbus));

        exp_t        sq[$];
        exp_t        se;
        exp_t        sd;
        logic [31:0] smodel = 0;
        logic [31:0] sshown = 0;
        bit          fin = 1'b0;
        int          st;
        logic        sm;
        logic        sacc;
        logic [SW-1:0] sx;
        logic [SW-1:0] sy;

        always @(negedge CLOCK) begin
            if (!rst_sw) begin
                if (sbus.done) begin
                    check($sformatf("sw%0d_done_busy_excl", g), 32'(sbus.busy), 0);
                    if (sq.size() == 0) begin
                        check($sformatf("sw%0d_unexpected_done", g), 32'(sbus.done), 0);
                    end else begin
                        se = sq.pop_front();
                        check($sformatf("sw%0d_F", g), 32'(sbus.F), se.f);
                        check($sformatf("sw%0d_flags", g),
                              {28'b0, sbus.sign, sbus.zero, sbus.overflow, sbus.carryOut}, 32'(se.flags));
                        check($sformatf("sw%0d_latency", g), 32'(cyc - se.start_cyc), SN);
                        sshown = se.f;
                    end
                end else if (sbus.busy) begin
                    check($sformatf("sw%0d_F_hold", g), 32'(sbus.F), sshown);
                end
            end
        end

        initial begin
            sbus.start = 1'b0;
            sbus.M     = 1'b0;
            sbus.ACC   = 1'b0;
            sbus.X     = '0;
            sbus.Y     = '0;
            #20;
            for (int i = 0; i < 40; i++) begin
                @(negedge CLOCK);
                st = 0;
                while (sbus.busy && st <= 100) begin
                    st++;
                    @(negedge CLOCK);
                end
                if (sbus.busy) check($sformatf("sw%0d_issue_wait", g), 32'(sbus.busy), 0);
                sm   = 1'($urandom);
                sacc = ($urandom_range(0, 3) == 0);
                sx   = SW'($urandom);
                sy   = SW'($urandom);
                sbus.start = 1'b1;
                sbus.M     = sm;
                sbus.ACC   = sacc;
                sbus.X     = sx;
                sbus.Y     = sy;
                sd = model(SW, sm, sacc ? smodel : 32'(sx), 32'(sy));
                sd.start_cyc = cyc + 1;
                smodel = sd.f;
                sq.push_back(sd);
                @(posedge CLOCK);
                #1;
                sbus.start = 1'b0;
                sbus.X     = SW'($urandom);
                sbus.Y     = SW'($urandom);
            end
            st = 0;
            while ((sq.size() != 0 || sbus.busy) && st <= 100) begin
                st++;
                @(negedge CLOCK);
            end
            check($sformatf("sw%0d_drain", g), 32'(sq.size()), 0);
            fin = 1'b1;
        end
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        int d;
        int t;
        bus.start = 1'b0;
        bus.M     = 1'b0;
        bus.ACC   = 1'b0;
        bus.X     = '0;
        bus.Y     = '0;
        #1;
        RESET  = 1'b1;
        rst_sw = 1'b1;
        #5;
        check("rst_F", 32'(bus.F), 0);
        check("rst_flags", {28'b0, bus.sign, bus.zero, bus.overflow, bus.carryOut}, 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        #6;
        RESET  = 1'b0;
        rst_sw = 1'b0;

        issue(1'b0, 1'b0, 8'h7F, 8'h01); drain(); check_res("add_7f_01", 8'h80, 4'b1010);
        issue(1'b0, 1'b0, 8'hFF, 8'h01); drain(); check_res("add_ff_01", 8'h00, 4'b0101);
        issue(1'b1, 1'b0, 8'h03, 8'h05); drain(); check_res("sub_03_05", 8'hFE, 4'b1001);
        issue(1'b1, 1'b0, 8'h05, 8'h05); drain(); check_res("sub_05_05", 8'h00, 4'b0100);
        issue(1'b1, 1'b0, 8'h80, 8'h01); drain(); check_res("sub_80_01", 8'h7F, 4'b0010);

        // Chain: each follow-up start lands in the previous op's done cycle.
        issue(1'b0, 1'b0, 8'h10, 8'h20);
        issue(1'b0, 1'b1, 8'hAA, 8'h05);
        issue(1'b1, 1'b1, 8'hAA, 8'h35);
        drain(); check_res("chain_end", 8'h00, 4'b0100);

        // A second start one cycle after acceptance must be ignored.
        d = dones0;
        issue(1'b0, 1'b0, 8'h11, 8'h22);
        @(negedge CLOCK);
        bus.start = 1'b1;
        bus.X     = 8'hF0;
        bus.Y     = 8'hF0;
        @(posedge CLOCK);
        #1;
        bus.start = 1'b0;
        drain();
        repeat (4) @(negedge CLOCK);
        check("ignored_start_dones", 32'(dones0 - d), 1);
        check_res("ignored_start", 8'h33, 4'b0000);

        // Asynchronous reset in the middle of RUN aborts the operation.
        issue(1'b0, 1'b0, 8'h12, 8'h34);
        @(negedge CLOCK);
        #2;
        RESET = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_F", 32'(bus.F), 0);
        check("abort_flags", {28'b0, bus.sign, bus.zero, bus.overflow, bus.carryOut}, 0);
        q0.delete();
        model_f0 = 0;
        shown_f0 = 0;
        d = dones0;
        @(negedge CLOCK);
        #2;
        RESET = 1'b0;
        repeat (6) @(negedge CLOCK);
        check("abort_no_done", 32'(dones0 - d), 0);

        for (int i = 0; i < 60; i++)
            issue(1'($urandom), ($urandom_range(0, 3) == 0), W'($urandom), W'($urandom));
        drain();

        t = 0;
        while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin) && t < 2000) begin
            t++;
            @(negedge CLOCK);
        end
        check("sweep_complete", 32'(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
